// File: rtl/i2c_master_byte.sv
// Byte-oriented I2C master bit engine: clocks one data byte plus its ACK bit
// onto an open-drain bus. It handles clock stretching with an optional timeout
// and detects lost arbitration on write data bits.
module i2c_master_byte #(
  parameter int DATA_WIDTH    = 8,
  parameter int DIV_WIDTH     = 8,
  parameter int TIMEOUT_WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     rw_read,
  input  logic [DATA_WIDTH-1:0]    tx_data,
  input  logic                     ack_in,
  input  logic [DIV_WIDTH-1:0]     quarter_div,
  input  logic [TIMEOUT_WIDTH-1:0] stretch_timeout,
  input  logic                     scl_in,
  input  logic                     sda_in,
  output logic                     scl_drive_low,
  output logic                     sda_drive_low,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    rx_data,
  output logic                     ack_rcvd,
  output logic                     timeout,
  output logic                     arb_lost
);

  // The bit index counts DATA_WIDTH down to 1 for data bits; 0 is the ACK bit.
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(DATA_WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST_DATA = IDX_W'(1);

  typedef enum logic [2:0] {IDLE, SETUP, RISE, HIGH, DONE} state_t;

  state_t                   state_reg, state_next;
  logic [IDX_W-1:0]         bit_idx_reg, bit_idx_next;
  logic [DIV_WIDTH-1:0]     phase_cnt_reg, phase_cnt_next;
  logic [TIMEOUT_WIDTH-1:0] stretch_cnt_reg, stretch_cnt_next;
  logic                     rw_reg, rw_next;
  logic                     ack_in_reg, ack_in_next;
  logic [DATA_WIDTH-1:0]    tx_shift_reg, tx_shift_next;
  logic [DIV_WIDTH-1:0]     q_reg, q_next;
  logic [TIMEOUT_WIDTH-1:0] to_reg, to_next;
  logic [DATA_WIDTH-2:0]    rx_shift_reg, rx_shift_next;
  logic [DATA_WIDTH-1:0]    rx_data_reg, rx_data_next;
  logic                     ack_reg, ack_next;
  logic                     timeout_reg, timeout_next;
  logic                     arb_reg, arb_next;
  // Level SCL is parked at while idle: held low after a clean byte so the
  // bus stays owned, released after reset or an aborted transfer.
  logic                     park_reg, park_next;

  logic [DIV_WIDTH-1:0]     q_eff;
  logic                     phase_last;
  logic [TIMEOUT_WIDTH-1:0] stretch_inc;
  logic                     sda_bit;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      bit_idx_reg     <= '0;
      phase_cnt_reg   <= '0;
      stretch_cnt_reg <= '0;
      rw_reg          <= 1'b0;
      ack_in_reg      <= 1'b0;
      tx_shift_reg    <= '0;
      q_reg           <= '0;
      to_reg          <= '0;
      rx_shift_reg    <= '0;
      rx_data_reg     <= '0;
      ack_reg         <= 1'b0;
      timeout_reg     <= 1'b0;
      arb_reg         <= 1'b0;
      park_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      bit_idx_reg     <= bit_idx_next;
      phase_cnt_reg   <= phase_cnt_next;
      stretch_cnt_reg <= stretch_cnt_next;
      rw_reg          <= rw_next;
      ack_in_reg      <= ack_in_next;
      tx_shift_reg    <= tx_shift_next;
      q_reg           <= q_next;
      to_reg          <= to_next;
      rx_shift_reg    <= rx_shift_next;
      rx_data_reg     <= rx_data_next;
      ack_reg         <= ack_next;
      timeout_reg     <= timeout_next;
      arb_reg         <= arb_next;
      park_reg        <= park_next;
    end
  end

  // Next-state logic: phase sequencing, stretch timeout, sampling, arbitration
  always_comb begin
    state_next       = state_reg;
    bit_idx_next     = bit_idx_reg;
    phase_cnt_next   = phase_cnt_reg;
    stretch_cnt_next = stretch_cnt_reg;
    rw_next          = rw_reg;
    ack_in_next      = ack_in_reg;
    tx_shift_next    = tx_shift_reg;
    q_next           = q_reg;
    to_next          = to_reg;
    rx_shift_next    = rx_shift_reg;
    rx_data_next     = rx_data_reg;
    ack_next         = ack_reg;
    timeout_next     = timeout_reg;
    arb_next         = arb_reg;
    park_next        = park_reg;

    q_eff       = (q_reg == '0) ? DIV_WIDTH'(1) : q_reg;
    phase_last  = (phase_cnt_reg == q_eff - DIV_WIDTH'(1));
    stretch_inc = stretch_cnt_reg + TIMEOUT_WIDTH'(1);

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          rw_next        = rw_read;
          ack_in_next    = ack_in;
          tx_shift_next  = tx_data;
          q_next         = quarter_div;
          to_next        = stretch_timeout;
          ack_next       = 1'b0;
          timeout_next   = 1'b0;
          arb_next       = 1'b0;
          bit_idx_next   = IDX_FIRST;
          phase_cnt_next = '0;
          state_next     = SETUP;
        end
      end
      SETUP: begin
        if (phase_last) begin
          phase_cnt_next   = '0;
          stretch_cnt_next = '0;
          state_next       = RISE;
        end else begin
          phase_cnt_next = phase_cnt_reg + DIV_WIDTH'(1);
        end
      end
      RISE: begin
        if (scl_in) begin
          phase_cnt_next = '0;
          state_next     = HIGH;
        end else begin
          // Hold at all-ones when the timeout is disabled instead of wrapping.
          if (stretch_cnt_reg != '1) stretch_cnt_next = stretch_inc;
          if (to_reg != '0 && stretch_inc == to_reg) begin
            timeout_next = 1'b1;
            park_next    = 1'b0;
            state_next   = DONE;
          end
        end
      end
      HIGH: begin
        if (phase_last) begin
          phase_cnt_next = '0;
          if (bit_idx_reg != '0) begin
            if (!rw_reg && tx_shift_reg[DATA_WIDTH-1] && !sda_in) begin
              arb_next   = 1'b1;
              park_next  = 1'b0;
              state_next = DONE;
            end else begin
              rx_shift_next = (DATA_WIDTH-1)'({rx_shift_reg, sda_in});
              if (rw_reg && bit_idx_reg == IDX_LAST_DATA)
                rx_data_next = {rx_shift_reg, sda_in};
              tx_shift_next = tx_shift_reg << 1;
              bit_idx_next  = bit_idx_reg - IDX_W'(1);
              state_next    = SETUP;
            end
          end else begin
            ack_next   = rw_reg ? ack_in_reg : ~sda_in;
            park_next  = 1'b1;
            state_next = DONE;
          end
        end else begin
          phase_cnt_next = phase_cnt_reg + DIV_WIDTH'(1);
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus drive and status outputs decoded from the current state
  always_comb begin
    if (bit_idx_reg != '0) sda_bit = ~rw_reg & ~tx_shift_reg[DATA_WIDTH-1];
    else                   sda_bit = rw_reg & ack_in_reg;

    busy          = (state_reg != IDLE);
    done          = (state_reg == DONE);
    scl_drive_low = park_reg;
    sda_drive_low = 1'b0;
    unique case (state_reg)
      SETUP: begin
        scl_drive_low = 1'b1;
        sda_drive_low = sda_bit;
      end
      RISE, HIGH: begin
        scl_drive_low = 1'b0;
        sda_drive_low = sda_bit;
      end
      default: ;
    endcase
  end

  assign rx_data  = rx_data_reg;
  assign ack_rcvd = ack_reg;
  assign timeout  = timeout_reg;
  assign arb_lost = arb_reg;

endmodule

// File: tb/tb_i2c_master_byte.sv
// Directed bench for i2c_master_byte with a small open-drain slave model.
module tb_i2c_master_byte;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        rw_read = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        ack_in = 1'b0;
  logic [7:0]  quarter_div = 8'd1;
  logic [10:0] stretch_timeout = 11'd0;
  logic        scl_in, sda_in;
  logic        scl_drive_low, sda_drive_low, busy, done;
  logic [7:0]  rx_data;
  logic        ack_rcvd, timeout, arb_lost;

  // Slave model state
  int          slave_mode = 0;   // 0 none, 1 ACK write, 2 send slave_byte, 3 pull SDA on bit 1
  int          stretch_mode = 0; // 0 none, 1 stretch 5 cycles on bit 3, 2 SCL stuck low
  logic [7:0]  slave_byte = 8'h00;
  int          bitk = 0;
  int          st = 0;
  int          rises = 0;
  logic [7:0]  cap = 8'h00;
  logic        prev_scl = 1'b0;
  logic        slave_low, stretch_low;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign scl_in = ~scl_drive_low & ~stretch_low;
  assign sda_in = ~sda_drive_low & ~slave_low;

  i2c_master_byte dut (
    .clk(clk), .reset(reset), .start(start), .rw_read(rw_read), .tx_data(tx_data),
    .ack_in(ack_in), .quarter_div(quarter_div), .stretch_timeout(stretch_timeout),
    .scl_in(scl_in), .sda_in(sda_in), .scl_drive_low(scl_drive_low),
    .sda_drive_low(sda_drive_low), .busy(busy), .done(done), .rx_data(rx_data),
    .ack_rcvd(ack_rcvd), .timeout(timeout), .arb_lost(arb_lost)
  );

  always_comb begin
    slave_low = 1'b0;
    case (slave_mode)
      1: slave_low = (bitk == 8);
      2: if (bitk < 8) slave_low = ~slave_byte[7 - bitk];
      3: slave_low = (bitk == 1);
      default: slave_low = 1'b0;
    endcase
    stretch_low = (stretch_mode == 1 && bitk == 3 && st <= 5) || (stretch_mode == 2);
  end

  // Track SCL edges on the bus: bit number, rising count, captured SDA levels
  always @(negedge clk) begin
    if (!busy) begin
      bitk = 0; st = 0; rises = 0; cap = 8'h00; prev_scl = 1'b0;
    end else begin
      if (!prev_scl && scl_in) begin
        rises++;
        if (bitk < 8) cap = {cap[6:0], sda_in};
      end
      if (prev_scl && !scl_in) bitk++;
      if (stretch_mode == 1 && bitk == 3 && !scl_drive_low) st++;
      prev_scl = scl_in;
    end
  end

  task automatic run_xfer(input logic rw, input logic [7:0] tx, input logic ack,
                          input logic [7:0] q, input logic [10:0] to, input int budget,
                          output int dcyc, output logic [2:0] flags1);
    @(negedge clk);
    rw_read = rw; tx_data = tx; ack_in = ack; quarter_div = q; stretch_timeout = to;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcyc = 1;
    flags1 = {ack_rcvd, timeout, arb_lost};
    while (!done && dcyc < budget) begin
      @(negedge clk);
      dcyc++;
    end
    if (!done) dcyc = -1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({scl_drive_low, sda_drive_low, busy, done, rx_data, ack_rcvd, timeout, arb_lost} !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 0",
               {scl_drive_low, sda_drive_low, busy, done, rx_data, ack_rcvd, timeout, arb_lost});
    end
    reset = 1'b0;
    $display("reset: outputs checked");
  endtask

  task automatic test_write_ack();
    int d; logic [2:0] f1;
    slave_mode = 1; stretch_mode = 0;
    run_xfer(1'b0, 8'hA5, 1'b0, 8'd2, 11'd0, 200, d, f1);
    n_cmp++; if (d !== 46) begin n_bad++; $display("FAIL write_done_cycle: got %0d want 46", d); end
    n_cmp++; if (cap !== 8'hA5) begin n_bad++; $display("FAIL write_sda_pattern: got %h want a5", cap); end
    n_cmp++; if (ack_rcvd !== 1'b1) begin n_bad++; $display("FAIL write_ack: got %b want 1", ack_rcvd); end
    n_cmp++; if ({timeout, arb_lost} !== 2'b00) begin n_bad++; $display("FAIL write_flags: got %b want 00", {timeout, arb_lost}); end
    @(negedge clk);
    n_cmp++; if ({done, busy} !== 2'b00) begin n_bad++; $display("FAIL write_done_pulse: got done,busy=%b want 00", {done, busy}); end
    n_cmp++; if ({scl_drive_low, sda_drive_low} !== 2'b10) begin n_bad++; $display("FAIL write_park_lines: got %b want 10", {scl_drive_low, sda_drive_low}); end
    $display("write A5 Q=2: done at %0d sda %h ack %b", d, cap, ack_rcvd);
  endtask

  task automatic test_read_stretch();
    int d; logic [2:0] f1;
    slave_mode = 2; slave_byte = 8'h3C; stretch_mode = 1;
    run_xfer(1'b1, 8'h00, 1'b0, 8'd1, 11'd20, 200, d, f1);
    n_cmp++; if (f1 !== 3'b000) begin n_bad++; $display("FAIL read_flags_cleared: got %b want 000", f1); end
    n_cmp++; if (d !== 33) begin n_bad++; $display("FAIL read_done_cycle: got %0d want 33", d); end
    n_cmp++; if (rx_data !== 8'h3C) begin n_bad++; $display("FAIL read_rx_data: got %h want 3c", rx_data); end
    n_cmp++; if ({ack_rcvd, timeout, arb_lost} !== 3'b000) begin n_bad++; $display("FAIL read_flags: got %b want 000", {ack_rcvd, timeout, arb_lost}); end
    repeat (10) @(negedge clk);
    n_cmp++; if (rx_data !== 8'h3C) begin n_bad++; $display("FAIL read_rx_hold: got %h want 3c", rx_data); end
    stretch_mode = 0;
    $display("read 3C Q=1 stretched: done at %0d rx %h", d, rx_data);
  endtask

  task automatic test_timeout();
    int d; logic [2:0] f1;
    slave_mode = 0; stretch_mode = 2;
    run_xfer(1'b0, 8'h00, 1'b0, 8'd1, 11'd10, 100, d, f1);
    n_cmp++; if (d !== 12) begin n_bad++; $display("FAIL timeout_done_cycle: got %0d want 12", d); end
    n_cmp++; if ({ack_rcvd, timeout, arb_lost} !== 3'b010) begin n_bad++; $display("FAIL timeout_flags: got %b want 010", {ack_rcvd, timeout, arb_lost}); end
    n_cmp++; if ({scl_drive_low, sda_drive_low} !== 2'b00) begin n_bad++; $display("FAIL timeout_lines: got %b want 00", {scl_drive_low, sda_drive_low}); end
    @(negedge clk);
    n_cmp++; if ({done, busy, scl_drive_low} !== 3'b000) begin n_bad++; $display("FAIL timeout_after: got %b want 000", {done, busy, scl_drive_low}); end
    stretch_mode = 0;
    $display("timeout stuck SCL: done at %0d timeout %b", d, timeout);
  endtask

  task automatic test_arbitration();
    int d; logic [2:0] f1;
    slave_mode = 3; stretch_mode = 0;
    run_xfer(1'b0, 8'hFF, 1'b0, 8'd1, 11'd0, 100, d, f1);
    n_cmp++; if (f1 !== 3'b000) begin n_bad++; $display("FAIL arb_flags_cleared: got %b want 000", f1); end
    n_cmp++; if (d !== 7) begin n_bad++; $display("FAIL arb_done_cycle: got %0d want 7", d); end
    n_cmp++; if ({ack_rcvd, timeout, arb_lost} !== 3'b001) begin n_bad++; $display("FAIL arb_flags: got %b want 001", {ack_rcvd, timeout, arb_lost}); end
    n_cmp++; if (rises !== 2) begin n_bad++; $display("FAIL arb_scl_pulses: got %0d want 2", rises); end
    n_cmp++; if ({scl_drive_low, sda_drive_low} !== 2'b00) begin n_bad++; $display("FAIL arb_lines: got %b want 00", {scl_drive_low, sda_drive_low}); end
    repeat (5) @(negedge clk);
    n_cmp++; if (arb_lost !== 1'b1) begin n_bad++; $display("FAIL arb_hold: got %b want 1", arb_lost); end
    slave_mode = 0;
    $display("write FF arbitration: done at %0d arb %b", d, arb_lost);
  endtask

  task automatic test_q_zero();
    int d; logic [2:0] f1;
    slave_mode = 0; stretch_mode = 0;
    run_xfer(1'b0, 8'h5A, 1'b0, 8'd0, 11'd0, 100, d, f1);
    n_cmp++; if (d !== 28) begin n_bad++; $display("FAIL qzero_done_cycle: got %0d want 28", d); end
    n_cmp++; if (cap !== 8'h5A) begin n_bad++; $display("FAIL qzero_sda_pattern: got %h want 5a", cap); end
    n_cmp++; if ({ack_rcvd, arb_lost} !== 2'b00) begin n_bad++; $display("FAIL qzero_nack: got %b want 00", {ack_rcvd, arb_lost}); end
    $display("write 5A Q=0: done at %0d sda %h ack %b", d, cap, ack_rcvd);
  endtask

  task automatic test_busy_start_reset();
    int seen;
    slave_mode = 0; stretch_mode = 0;
    @(negedge clk);
    rw_read = 1'b0; tx_data = 8'hA5; quarter_div = 8'd1; stretch_timeout = 11'd0; start = 1'b1;
    @(negedge clk);                 // cycle 1
    start = 1'b0;
    repeat (2) @(negedge clk);      // cycle 3
    rw_read = 1'b1; tx_data = 8'h00; start = 1'b1;
    @(negedge clk);                 // cycle 4
    start = 1'b0;
    repeat (12) @(negedge clk);     // cycle 16
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_start_busy: got %b want 1", busy); end
    n_cmp++; if (cap !== 8'h14) begin n_bad++; $display("FAIL busy_start_ignored: got %h want 14", cap); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({scl_drive_low, sda_drive_low, busy, done, rx_data, ack_rcvd, timeout, arb_lost} !== 14'd0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got %b want 0",
               {scl_drive_low, sda_drive_low, busy, done, rx_data, ack_rcvd, timeout, arb_lost});
    end
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midreset_no_done: got %0d active cycles want 0", seen); end
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    n_cmp++; if ({busy, scl_drive_low} !== 2'b00) begin n_bad++; $display("FAIL reset_over_start: got %b want 00", {busy, scl_drive_low}); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_over_start_idle: got %b want 0", busy); end
    $display("busy start + mid reset: idle cycles active %0d", seen);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_ack();
    test_read_stretch();
    test_timeout();
    test_arbitration();
    test_q_zero();
    test_busy_start_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_master_byte.md
I2C_MASTER_BYTE -- requirements
Module: i2c_master_byte

Interface
REQ-001 Parameter DATA_WIDTH, default 8: data bits per transfer, excluding the ACK bit.
REQ-002 Parameter DIV_WIDTH, default 8: width of quarter_div.
REQ-003 Parameter TIMEOUT_WIDTH, default 11: width of stretch_timeout.
REQ-004 clk  input  1: single clock; all logic on the rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 start  input  1: request one transfer; sampled only in IDLE.
REQ-007 rw_read  input  1: 1 = read transfer, 0 = write transfer.
REQ-008 tx_data  input  DATA_WIDTH: write data, sent MSB first.
REQ-009 ack_in  input  1: read mode only; 1 = master drives ACK (SDA low), 0 = NACK.
REQ-010 quarter_div  input  DIV_WIDTH: phase length Q in clk cycles; value 0 is treated as 1.
REQ-011 stretch_timeout  input  TIMEOUT_WIDTH: maximum clock-stretch cycles; 0 disables the timeout.
REQ-012 scl_in, sda_in  input  1 each: sampled bus line levels.
REQ-013 scl_drive_low, sda_drive_low  output  1 each: 1 = pull line low, 0 = release (open drain).
REQ-014 busy  output  1: transfer in progress.
REQ-015 done  output  1: single-cycle end-of-transfer pulse.
REQ-016 rx_data  output  DATA_WIDTH: read data.
REQ-017 ack_rcvd, timeout, arb_lost  output  1 each: transfer status flags.

Function
REQ-018 States SHALL be IDLE, SETUP, RISE, HIGH and DONE; no other states.
REQ-019 IDLE with start=1: latch all inputs from REQ-006 to REQ-011, clear ack_rcvd/timeout/arb_lost, set bit index to DATA_WIDTH, go to SETUP; busy=1 from the next cycle.
REQ-020 start when not in IDLE SHALL be ignored; latched inputs stay unchanged.
REQ-021 SETUP: scl_drive_low=1 and sda_drive_low set per REQ-025 for Q cycles, then go to RISE.
REQ-022 RISE: scl_drive_low=0; if scl_in=1, go to HIGH next cycle; otherwise increment the stretch counter.
REQ-023 Stretch counter clears on every entry to RISE; when it equals a nonzero stretch_timeout: timeout=1, release both lines, go to DONE.
REQ-024 HIGH: held for Q cycles; sda_in sampled on the last HIGH cycle; then scl_drive_low=1 and move to the next bit's SETUP, or to DONE after the ACK bit.
REQ-025 SDA per bit:
- write data bit: sda_drive_low = ~bit
- read data bit: released
- ACK bit, write mode: released
- ACK bit, read mode: sda_drive_low = ack_in
REQ-026 Read: sampled data bits SHALL shift into rx_data MSB first; rx_data is updated only on the final data-bit sample.
REQ-027 Write ACK bit: ack_rcvd = ~sampled sda_in. Read ACK bit: ack_rcvd = ack_in.
REQ-028 Arbitration: on a write data bit with SDA released and sda_in sampled 0, set arb_lost=1, release both lines, go to DONE. Arbitration SHALL NOT be checked on the ACK bit or in read mode.
REQ-029 DONE: one cycle with done=1, busy=0 on the following cycle, return to IDLE.
REQ-030 Line state after DONE:
- normal end: scl_drive_low=1, sda_drive_low=0
- after timeout or arb_lost: both lines 0
REQ-031 Flags and rx_data SHALL hold until the next accepted start.
REQ-032 Latency without stretching: done asserts exactly 1+(DATA_WIDTH+1)*(2Q+1) cycles after the start cycle, with scl_in tied combinationally to ~scl_drive_low.
REQ-033 Counters SHALL saturate-free compare at full parameter width; no wrap-around is permitted within one phase.

Reset
REQ-034 On reset: state=IDLE; scl_drive_low, sda_drive_low, busy, done, rx_data, ack_rcvd, timeout, arb_lost and all counters = 0.
REQ-035 Reset mid-transfer SHALL take effect at the next edge, with no done pulse.
REQ-036 Reset SHALL override a simultaneous start.

Verification
REQ-037 Write 0xA5, Q=2, slave ACKs (pulls SDA low in ACK HIGH) -> SDA pattern 1,0,1,0,0,1,0,1; done at cycle 46; ack_rcvd=1.
REQ-038 Read, Q=1, slave returns 0x3C, ack_in=0, scl_in held low 5 cycles on bit 3, stretch_timeout=20 -> rx_data=0x3C, ack_rcvd=0, timeout=0, done at cycle 33.
REQ-039 stretch_timeout=10, scl_in stuck 0 -> timeout=1 after 10 RISE cycles; lines released; done=1 for one cycle.
REQ-040 Write 0xFF, bus forces sda_in=0 at bit 6 sample -> arb_lost=1; both lines released; no ACK bit issued.
REQ-041 start pulsed while busy, then reset asserted mid-byte -> no second transfer; all outputs 0 next cycle; no done.
